// File: rtl/muldiv_hilo_unit.sv
// Iterative 32x32 unsigned multiply / 32/32 unsigned restoring divide with HI/LO
// result registers, one iteration per clock, plus MFHI/MFLO read mux and pipeline stall.
module muldiv_hilo_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        MD_start,
    input  logic [11:0] MD_control,
    input  logic [31:0] MD_IN_1,
    input  logic [31:0] MD_IN_2,
    output logic        MD_busy,
    output logic        MD_done,
    output logic        MD_stall,
    output logic        MD_div0,
    output logic [31:0] HI_out,
    output logic [31:0] LO_out,
    output logic [31:0] MD_OUT32,
    output logic [1:0]  dbg_state
);

    localparam logic [11:0] CTRL_MULT = 12'b000011011000;
    localparam logic [11:0] CTRL_DIV  = 12'b000011011010;
    localparam logic [11:0] CTRL_MFHI = 12'b000011010000;
    localparam logic [11:0] CTRL_MFLO = 12'b000011010010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q;
    logic [31:0] hi_q, lo_q;
    logic        div0_q;
    // MUL: {partial product, remaining multiplier}; DIV: {partial remainder, dividend/quotient}
    logic [63:0] acc_q;
    logic [31:0] op_b_q;

    logic        is_mult, is_div, is_mf, div_zero, accept, last_iter;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic [63:0] div_next;

    assign is_mult   = (MD_control == CTRL_MULT);
    assign is_div    = (MD_control == CTRL_DIV);
    assign is_mf     = (MD_control == CTRL_MFHI) || (MD_control == CTRL_MFLO);
    assign div_zero  = (MD_IN_2 == 32'd0);
    assign last_iter = (cnt_q == 5'd31);

    // Handshake: a request is MD_start with MULT/DIV; it is taken on any edge where the
    // unit is IDLE or DONE. While busy, MD_stall tells the pipeline to keep holding it.
    assign accept = MD_start && (is_mult || is_div) && (state_q == S_IDLE || state_q == S_DONE);

    // Shift-add step: add multiplicand into the upper half when the current LSB is set.
    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, op_b_q} : 33'd0);
    assign mul_next = {mul_sum, acc_q[31:1]};

    // Restoring step: shift in the next dividend bit and subtract if it fits.
    assign div_shift = {acc_q[63:32], acc_q[31]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, op_b_q};
    assign div_next  = div_diff[33] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                                    : {div_diff[31:0],  acc_q[30:0], 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (is_mult)       state_d = S_MUL;
                    else if (div_zero) state_d = S_DONE;
                    else               state_d = S_DIV;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                if (last_iter) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= 5'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            div0_q <= 1'b0;
            acc_q  <= 64'd0;
            op_b_q <= 32'd0;
        end else if (accept) begin
            cnt_q  <= 5'd0;
            div0_q <= is_div && div_zero;
            op_b_q <= is_mult ? MD_IN_1 : MD_IN_2;
            acc_q  <= {32'd0, (is_mult ? MD_IN_2 : MD_IN_1)};
            if (is_div && div_zero) begin
                hi_q <= MD_IN_1;
                lo_q <= 32'hFFFF_FFFF;
            end
        end else if (state_q == S_MUL) begin
            acc_q <= mul_next;
            cnt_q <= cnt_q + 5'd1;
            if (last_iter) begin
                hi_q <= mul_next[63:32];
                lo_q <= mul_next[31:0];
            end
        end else if (state_q == S_DIV) begin
            acc_q <= div_next;
            cnt_q <= cnt_q + 5'd1;
            if (last_iter) begin
                hi_q <= div_next[63:32];
                lo_q <= div_next[31:0];
            end
        end
    end

    assign MD_busy   = (state_q == S_MUL) || (state_q == S_DIV);
    assign MD_done   = (state_q == S_DONE);
    assign MD_div0   = (state_q == S_DONE) && div0_q;
    assign MD_stall  = MD_busy && (MD_start || is_mf);
    assign HI_out    = hi_q;
    assign LO_out    = lo_q;
    assign dbg_state = state_q;

    always_comb begin
        MD_OUT32 = 32'd0;
        if (MD_control == CTRL_MFHI)      MD_OUT32 = hi_q;
        else if (MD_control == CTRL_MFLO) MD_OUT32 = lo_q;
    end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed bench for muldiv_hilo_unit: reset, MULT/DIV results and latency, divide by
// zero, reset abort, ignored requests, MFHI/MFLO reads and stalls, back-to-back starts.
module tb_muldiv_hilo_unit;

    localparam logic [11:0] C_MULT = 12'b000011011000;
    localparam logic [11:0] C_DIV  = 12'b000011011010;
    localparam logic [11:0] C_MFHI = 12'b000011010000;
    localparam logic [11:0] C_MFLO = 12'b000011010010;
    localparam logic [11:0] C_NOP  = 12'b000000000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MD_start = 1'b0;
    logic [11:0] MD_control = C_NOP;
    logic [31:0] MD_IN_1 = 32'd0;
    logic [31:0] MD_IN_2 = 32'd0;
    logic        MD_busy, MD_done, MD_stall, MD_div0;
    logic [31:0] HI_out, LO_out, MD_OUT32;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_hilo_unit dut (
        .clk        (clk),
        .rst        (rst),
        .MD_start   (MD_start),
        .MD_control (MD_control),
        .MD_IN_1    (MD_IN_1),
        .MD_IN_2    (MD_IN_2),
        .MD_busy    (MD_busy),
        .MD_done    (MD_done),
        .MD_stall   (MD_stall),
        .MD_div0    (MD_div0),
        .HI_out     (HI_out),
        .LO_out     (LO_out),
        .MD_OUT32   (MD_OUT32),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    // Drive a request at a falling edge, let one rising edge take it, then drop it.
    task automatic issue(input logic [11:0] c, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        MD_control = c;
        MD_IN_1    = a;
        MD_IN_2    = b;
        MD_start   = 1'b1;
        @(posedge clk);
        #1;
        MD_start   = 1'b0;
        MD_control = C_NOP;
        MD_IN_1    = $urandom;
        MD_IN_2    = $urandom;
    endtask

    // Count falling edges with MD_busy high; returns at the first falling edge with it low.
    task automatic count_busy(output int n);
        n = 0;
        @(negedge clk);
        while (MD_busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        MD_start = 1'b1;
        MD_control = C_MULT;
        MD_IN_1 = 32'd9;
        MD_IN_2 = 32'd9;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (MD_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", MD_busy); end
        n_checks++; if (MD_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", MD_done); end
        n_checks++; if (MD_div0 !== 1'b0) begin n_fail++; $display("FAIL reset_div0: got %b want 0", MD_div0); end
        n_checks++; if (HI_out !== 32'd0 || LO_out !== 32'd0) begin n_fail++; $display("FAIL reset_hilo: got %h/%h want 0/0", HI_out, LO_out); end
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        MD_start = 1'b0;
        MD_control = C_MFHI;
        rst = 1'b0;
        #1;
        n_checks++; if (MD_OUT32 !== 32'd0) begin n_fail++; $display("FAIL reset_mfhi: got %h want 0", MD_OUT32); end
        MD_control = C_NOP;
    endtask

    task automatic test_mult_max();
        int n;
        issue(C_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        count_busy(n);
        n_checks++; if (n !== 32) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d want 32", n); end
        n_checks++; if (MD_done !== 1'b1) begin n_fail++; $display("FAIL mult_done: got %b want 1", MD_done); end
        n_checks++; if (MD_div0 !== 1'b0) begin n_fail++; $display("FAIL mult_div0: got %b want 0", MD_div0); end
        n_checks++; if (HI_out !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mult_hi: got %h want fffffffe", HI_out); end
        n_checks++; if (LO_out !== 32'h0000_0001) begin n_fail++; $display("FAIL mult_lo: got %h want 00000001", LO_out); end
        @(negedge clk);
        n_checks++; if (MD_done !== 1'b0) begin n_fail++; $display("FAIL mult_done_width: got %b want 0", MD_done); end
    endtask

    task automatic test_div();
        int n;
        issue(C_DIV, 32'd100, 32'd7);
        count_busy(n);
        n_checks++; if (n !== 32) begin n_fail++; $display("FAIL div_busy_cycles: got %0d want 32", n); end
        n_checks++; if (MD_done !== 1'b1) begin n_fail++; $display("FAIL div_done: got %b want 1", MD_done); end
        n_checks++; if (HI_out !== 32'd2) begin n_fail++; $display("FAIL div_rem: got %h want 2", HI_out); end
        n_checks++; if (LO_out !== 32'h0000_000E) begin n_fail++; $display("FAIL div_quo: got %h want e", LO_out); end
        n_checks++; if (MD_div0 !== 1'b0) begin n_fail++; $display("FAIL div_div0: got %b want 0", MD_div0); end
        @(negedge clk);
        n_checks++; if (MD_done !== 1'b0) begin n_fail++; $display("FAIL div_done_width: got %b want 0", MD_done); end
    endtask

    task automatic test_div0();
        issue(C_DIV, 32'd5, 32'd0);
        @(negedge clk);
        n_checks++; if (MD_busy !== 1'b0) begin n_fail++; $display("FAIL div0_busy: got %b want 0", MD_busy); end
        n_checks++; if (MD_done !== 1'b1) begin n_fail++; $display("FAIL div0_done: got %b want 1", MD_done); end
        n_checks++; if (MD_div0 !== 1'b1) begin n_fail++; $display("FAIL div0_flag: got %b want 1", MD_div0); end
        n_checks++; if (HI_out !== 32'd5) begin n_fail++; $display("FAIL div0_hi: got %h want 5", HI_out); end
        n_checks++; if (LO_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div0_lo: got %h want ffffffff", LO_out); end
        @(negedge clk);
        n_checks++; if (MD_done !== 1'b0 || MD_div0 !== 1'b0) begin n_fail++; $display("FAIL div0_after: got done=%b div0=%b want 0/0", MD_done, MD_div0); end
    endtask

    task automatic test_reset_mid();
        bit seen_done;
        issue(C_MULT, 32'd3, 32'd4);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (MD_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", MD_busy); end
        n_checks++; if (HI_out !== 32'd0 || LO_out !== 32'd0) begin n_fail++; $display("FAIL rstmid_hilo: got %h/%h want 0/0", HI_out, LO_out); end
        seen_done = 1'b0;
        repeat (40) begin
            if (MD_done) seen_done = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_done: got %b want 0", seen_done); end
        n_checks++; if (LO_out !== 32'd0) begin n_fail++; $display("FAIL rstmid_lo_later: got %h want 0", LO_out); end
    endtask

    task automatic test_ignored_start();
        issue(C_MFHI, 32'd1, 32'd1);
        @(negedge clk);
        n_checks++; if (MD_busy !== 1'b0 || MD_done !== 1'b0) begin n_fail++; $display("FAIL ignored_start: got busy=%b done=%b want 0/0", MD_busy, MD_done); end
        n_checks++; if (HI_out !== 32'd0) begin n_fail++; $display("FAIL ignored_hi: got %h want 0", HI_out); end
    endtask

    task automatic test_busy_start();
        int n;
        issue(C_MULT, 32'h0001_0000, 32'h0001_0000);
        repeat (5) @(negedge clk);
        MD_start = 1'b1;
        MD_control = C_DIV;
        MD_IN_1 = 32'd9;
        MD_IN_2 = 32'd3;
        #1;
        n_checks++; if (MD_stall !== 1'b1) begin n_fail++; $display("FAIL busy_start_stall: got %b want 1", MD_stall); end
        @(negedge clk);
        n_checks++; if (MD_busy !== 1'b1 || dbg_state !== 2'd1) begin n_fail++; $display("FAIL busy_start_state: got busy=%b st=%0d want 1/1", MD_busy, dbg_state); end
        MD_start = 1'b0;
        MD_control = C_NOP;
        count_busy(n);
        n_checks++; if (MD_done !== 1'b1) begin n_fail++; $display("FAIL busy_start_done: got %b want 1", MD_done); end
        n_checks++; if (HI_out !== 32'd1 || LO_out !== 32'd0) begin n_fail++; $display("FAIL busy_start_result: got %h/%h want 1/0", HI_out, LO_out); end
        @(negedge clk);
        n_checks++; if (MD_busy !== 1'b0 || MD_done !== 1'b0) begin n_fail++; $display("FAIL busy_start_not_queued: got busy=%b done=%b want 0/0", MD_busy, MD_done); end
        MD_control = C_MFHI;
        #1;
        n_checks++; if (MD_OUT32 !== 32'd1 || MD_stall !== 1'b0) begin n_fail++; $display("FAIL mfhi_read: got %h stall=%b want 1/0", MD_OUT32, MD_stall); end
        MD_control = C_MFLO;
        #1;
        n_checks++; if (MD_OUT32 !== 32'd0) begin n_fail++; $display("FAIL mflo_read: got %h want 0", MD_OUT32); end
        MD_control = C_NOP;
    endtask

    task automatic test_mfhi_busy();
        int n;
        issue(C_MULT, 32'd7, 32'd6);
        MD_control = C_MFHI;
        n = 0;
        @(negedge clk);
        while (MD_busy && n < 100) begin
            n_checks++; if (MD_stall !== 1'b1 || MD_OUT32 !== 32'd1) begin n_fail++; $display("FAIL mfhi_busy_cyc%0d: got out=%h stall=%b want 1/1", n, MD_OUT32, MD_stall); end
            n++;
            @(negedge clk);
        end
        n_checks++; if (n !== 32) begin n_fail++; $display("FAIL mfhi_busy_cycles: got %0d want 32", n); end
        n_checks++; if (MD_done !== 1'b1 || MD_OUT32 !== 32'd0 || MD_stall !== 1'b0) begin n_fail++; $display("FAIL mfhi_after: got done=%b out=%h stall=%b want 1/0/0", MD_done, MD_OUT32, MD_stall); end
        MD_control = C_MFLO;
        #1;
        n_checks++; if (MD_OUT32 !== 32'd42) begin n_fail++; $display("FAIL mflo_after: got %h want 2a", MD_OUT32); end
        MD_control = C_NOP;
    endtask

    task automatic test_back_to_back();
        int n;
        issue(C_MULT, 32'd2, 32'd3);
        count_busy(n);
        n_checks++; if (MD_done !== 1'b1 || HI_out !== 32'd0 || LO_out !== 32'd6) begin n_fail++; $display("FAIL b2b_first: got done=%b %h/%h want 1 0/6", MD_done, HI_out, LO_out); end
        // Still at the DONE falling edge: the next rising edge must take this request.
        MD_control = C_DIV;
        MD_IN_1 = 32'd50;
        MD_IN_2 = 32'd8;
        MD_start = 1'b1;
        @(posedge clk);
        #1;
        MD_start = 1'b0;
        MD_control = C_NOP;
        MD_IN_2 = 32'd0;
        count_busy(n);
        n_checks++; if (n !== 32) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d want 32", n); end
        n_checks++; if (MD_done !== 1'b1 || HI_out !== 32'd2 || LO_out !== 32'd6) begin n_fail++; $display("FAIL b2b_second: got done=%b %h/%h want 1 2/6", MD_done, HI_out, LO_out); end
    endtask

    initial begin
        test_reset();
        test_mult_max();
        test_div();
        test_div0();
        test_reset_mid();
        test_ignored_start();
        test_busy_start();
        test_mfhi_busy();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
